// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: picks one finished FU per cycle, registers its
// payload onto the shared writeback port and stalls every other requester.
package wb_arbiter_pkg;
  typedef struct packed {
    logic [5:0]  rob_idx;
    logic [3:0]  irob_idx;
    logic        use_imm;
    logic        rd_wen;
    logic [6:0]  iprd_idx;
    logic [63:0] result;
  } comwbInfo_t;
endpackage

module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_FU = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_FU-1:0] i_fu_finished,
  input  comwbInfo_t        i_comwbInfo [NUM_FU],
  output logic [NUM_FU-1:0] o_fu_stall,
  input  logic              i_wb_stall,
  output logic              o_wb_vld,
  output comwbInfo_t        o_comwbInfo,
  output logic [CNT_W-1:0]  o_conflict_cnt
);

  localparam int PTR_W = $clog2(NUM_FU);
  localparam logic [PTR_W:0]   NUM_FU_W = (PTR_W+1)'(NUM_FU);
  localparam logic [PTR_W-1:0] LAST_FU  = PTR_W'(NUM_FU - 1);

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              wb_vld_q, wb_vld_d;
  comwbInfo_t        wb_info_q, wb_info_d;
  logic [CNT_W-1:0]  conflict_cnt_q, conflict_cnt_d;

  logic              grant_vld;
  logic [PTR_W-1:0]  grant_idx;
  logic [NUM_FU-1:0] grant_oh;
  logic [PTR_W:0]    cand;
  logic              multi_req;

  // Search starts at rr_ptr and wraps modulo NUM_FU; the extra bit in cand
  // absorbs the sum before the wrap so non-power-of-two counts work.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    cand      = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (cand >= NUM_FU_W) begin
        cand = cand - NUM_FU_W;
      end
      if (!grant_vld && i_fu_finished[cand[PTR_W-1:0]]) begin
        grant_vld                  = 1'b1;
        grant_idx                  = cand[PTR_W-1:0];
        grant_oh[cand[PTR_W-1:0]]  = 1'b1;
      end
    end
  end

  // Clearing the lowest set bit leaves something only when two or more FUs request.
  assign multi_req = |(i_fu_finished & (i_fu_finished - NUM_FU'(1)));

  always_comb begin
    if (!rst || i_wb_stall) begin
      o_fu_stall = '1;
    end else begin
      o_fu_stall = i_fu_finished & ~grant_oh;
    end
  end

  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    wb_vld_d       = wb_vld_q;
    wb_info_d      = wb_info_q;
    conflict_cnt_d = conflict_cnt_q;
    if (!i_wb_stall) begin
      wb_vld_d = grant_vld;
      if (grant_vld) begin
        wb_info_d = i_comwbInfo[grant_idx];
        rr_ptr_d  = (grant_idx == LAST_FU) ? '0 : grant_idx + PTR_W'(1);
      end
      if (multi_req && (conflict_cnt_q != '1)) begin
        conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q       <= '0;
      wb_vld_q       <= 1'b0;
      wb_info_q      <= '0;
      conflict_cnt_q <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      wb_vld_q       <= wb_vld_d;
      wb_info_q      <= wb_info_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign o_wb_vld       = wb_vld_q;
  assign o_comwbInfo    = wb_info_q;
  assign o_conflict_cnt = conflict_cnt_q;

endmodule
